// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i fetch constants, immediate extractors and fetch FSM encoding
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/btfn_predecode.sv
// rtl/btfn_predecode.sv - static backward-taken/forward-not-taken predecode of the fetched word
module btfn_predecode
  import rv32i_pkg::OP_BRANCH, rv32i_pkg::OP_JAL, rv32i_pkg::imm_b, rv32i_pkg::imm_j;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  logic is_jal;
  logic is_back_branch;

  assign is_jal         = (instr[6:0] == OP_JAL);
  // imm[12] is the sign bit of the branch offset, i.e. a backward branch
  assign is_back_branch = (instr[6:0] == OP_BRANCH) && instr[31];

  always_comb begin
    pred_taken  = is_jal || is_back_branch;
    pred_target = pc + 32'd4;
    if (is_jal)
      pred_target = pc + imm_j(instr);
    else if (is_back_branch)
      pred_target = pc + imm_b(instr);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i IF stage: PC register, next-PC select, IF/ID register
// Optional static branch prediction is enabled by defining STATIC_BTFN_EN.
module fetch_unit
  import rv32i_pkg::fetch_state_t, rv32i_pkg::S_BOOT, rv32i_pkg::S_RUN;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC   = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic        if_id_flush,
  input  logic        branch_taken_ex,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_pred_taken,
  output logic        misalign_trap,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_q;
  logic         pred_taken;
  logic [31:0]  pred_target;
  logic         trap_hit;
  logic         ifid_bubble;
  logic         ifid_load;

`ifdef STATIC_BTFN_EN
  btfn_predecode u_btfn_predecode (
    .instr       (imem_rdata),
    .pc          (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_q + 32'd4;
`endif

  assign pc        = pc_q;
  assign imem_addr = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_BOOT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    next_pc   = pc_q + 32'd4;
    trap_hit  = 1'b0;
    case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
        next_pc   = RESET_PC;
      end
      default: begin
        // a redirect from EX overrides both the stall and any prediction
        if (branch_taken_ex) begin
          if (branch_target[1:0] != 2'b00) begin
            next_pc  = TRAP_PC;
            trap_hit = 1'b1;
          end else begin
            next_pc = branch_target;
          end
        end else if (!pc_en) begin
          next_pc = pc_q;
        end else if (pred_taken) begin
          next_pc = pred_target;
        end
      end
    endcase
  end

  // the boot cycle loads a bubble so a reset release never presents a half-fetched word
  assign ifid_bubble = (state == S_BOOT) || if_id_flush || branch_taken_ex;
  assign ifid_load   = !ifid_bubble && if_id_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      if_id_instr      <= NOP_INSTR;
      if_id_pc         <= 32'h0;
      if_id_valid      <= 1'b0;
      if_id_pred_taken <= 1'b0;
      misalign_trap    <= 1'b0;
      fetch_count      <= 32'h0;
    end else begin
      pc_q <= next_pc;
      if (trap_hit)
        misalign_trap <= 1'b1;
      if (ifid_bubble) begin
        if_id_instr      <= NOP_INSTR;
        if_id_pc         <= 32'h0;
        if_id_valid      <= 1'b0;
        if_id_pred_taken <= 1'b0;
      end else if (ifid_load) begin
        if_id_instr      <= imem_rdata;
        if_id_pc         <= pc_q;
        if_id_valid      <= 1'b1;
        if_id_pred_taken <= pred_taken;
        fetch_count      <= fetch_count + 32'd1;
      end
    end
  end

endmodule
